// File: rtl/alu_req_arbiter.sv
// Two-requester front end for a shared registered ALU: arbitrates, drives the ALU, waits out its latency, returns the result.
// Optional: define ALU_ARB_FIXED_PRIO_EN for fixed r0-wins tie-break (default: round-robin).
module alu_req_arbiter #(
    parameter int W       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [2:0]   r0_op,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [2:0]   r1_op,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_carry,
    output logic         rsp_zero,
    output logic [W-1:0] alu_data1,
    output logic [W-1:0] alu_data2,
    output logic [2:0]   alu_ctrl,
    input  logic [W-1:0] alu_out,
    input  logic         alu_carry
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam int         CW      = $clog2(ALU_LAT + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] lat_cnt;
    logic          lat_done;
    logic          grant0;
    logic          grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic          last_grant;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (r0_valid && r1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = 1'b1;
`else
            // last_grant==1 means r1 was served last, so r0 takes the tie.
            grant0 = last_grant;
            grant1 = !last_grant;
`endif
        end else begin
            grant0 = r0_valid;
            grant1 = r1_valid;
        end
    end

    assign r0_ready = (state == IDLE) && grant0;
    assign r1_ready = (state == IDLE) && grant1;
    assign lat_done = (lat_cnt == CW'(ALU_LAT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant0 || grant1) state_nxt = EXEC;
            EXEC:    if (lat_done)         state_nxt = CAPT;
            CAPT:                          state_nxt = RESP;
            RESP:    if (rsp_ready)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_ctrl   <= OP_PASS;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (r0_ready || r1_ready) begin
                        alu_ctrl   <= r1_ready ? r1_op : r0_op;
                        alu_data1  <= r1_ready ? r1_a  : r0_a;
                        alu_data2  <= r1_ready ? r1_b  : r0_b;
                        rsp_id     <= r1_ready;
                        lat_cnt    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= r1_ready;
`endif
                    end
                end
                EXEC: lat_cnt <= lat_cnt + 1'b1;
                CAPT: begin
                    rsp_result <= alu_out;
                    // Carry is only meaningful for arithmetic; logic/pass ops report 0.
                    rsp_carry  <= ((alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB)) && alu_carry;
                    rsp_zero   <= (alu_out == '0);
                    rsp_valid  <= 1'b1;
                    alu_ctrl   <= OP_PASS;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
